// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: receiver FSM states and legal data-width range shared by the UART RX files.
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;
endpackage

// File: rtl/uart_rx_framer_if.sv
// uart_rx_framer_if: serial line, sample tick and valid/ready byte output of the UART receiver.
interface uart_rx_framer_if #(parameter int DATA_BITS = 8);
  logic SAMPLE_TICK;
  logic RXD;
  logic PARITY_ODD;
  logic RX_READY;
  logic [DATA_BITS-1:0] RX_DATA;
  logic RX_VALID;
  logic RXRDY;
  logic FRAME_ERROR;
  logic PARITY_ERROR;
  logic OVERRUN;
  modport master (output SAMPLE_TICK, RXD, PARITY_ODD, RX_READY,
                  input RX_DATA, RX_VALID, RXRDY, FRAME_ERROR, PARITY_ERROR, OVERRUN);
  modport slave (input SAMPLE_TICK, RXD, PARITY_ODD, RX_READY,
                 output RX_DATA, RX_VALID, RXRDY, FRAME_ERROR, PARITY_ERROR, OVERRUN);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for RXD plus a falling-edge detector on the synced line.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk) s <= rst ? 3'b111 : {s[1:0], d};
  assign q = s[1];
  assign fall = s[2] & ~s[1];
endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampled UART receiver with false-start rejection, frame/overrun flags.
// Define UART_RX_PARITY_EN to receive and check one parity bit after the data bits.
module uart_rx_framer
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input logic CLK,
  input logic RST,
  uart_rx_framer_if.slave rx
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SLAST = BW'(STOP_BITS - 1);
  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS || OVERSAMPLE < 4 ||
      OVERSAMPLE % 2 != 0 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("uart_rx_framer: illegal parameter combination");
  end
  rx_state_e state;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic [DATA_BITS-1:0] sh;
  logic ferr, perr, load, rxd_s, fall, mid;
  uart_rx_sync u_sync (.clk(CLK), .rst(RST), .d(rx.RXD), .q(rxd_s), .fall(fall));
  assign mid = rx.SAMPLE_TICK && tcnt == LAST;
  // tick counter free-runs modulo OVERSAMPLE; START re-phases it to mid-bit
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      tcnt <= '0;
      bcnt <= '0;
      sh <= '0;
      ferr <= 1'b0;
      perr <= 1'b0;
      load <= 1'b0;
      rx.RXRDY <= 1'b1;
    end else begin
      load <= 1'b0;
      if (rx.SAMPLE_TICK) tcnt <= (tcnt == LAST) ? '0 : tcnt + 1'b1;
      case (state)
        IDLE: if (fall) begin
          state <= START;
          tcnt <= '0;
          rx.RXRDY <= 1'b0;
        end
        START: if (rx.SAMPLE_TICK && tcnt == HALF) begin
          tcnt <= '0;
          bcnt <= '0;
          ferr <= 1'b0;
          perr <= 1'b0;
          state <= rxd_s ? IDLE : DATA;
          rx.RXRDY <= rxd_s;
        end
        DATA: if (mid) begin
          sh <= {rxd_s, sh[DATA_BITS-1:1]};
          bcnt <= (bcnt == DLAST) ? '0 : bcnt + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bcnt == DLAST) state <= PARITY;
`else
          if (bcnt == DLAST) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (mid) begin
          perr <= (^sh ^ rxd_s) != rx.PARITY_ODD;
          state <= STOP;
        end
`endif
        STOP: if (mid) begin
          if (!rxd_s) ferr <= 1'b1;
          bcnt <= bcnt + 1'b1;
          if (bcnt == SLAST) begin
            state <= IDLE;
            rx.RXRDY <= 1'b1;
            load <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // a load wins over a same-cycle handshake, so the new word stays valid
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx.RX_DATA <= '0;
      rx.RX_VALID <= 1'b0;
      rx.FRAME_ERROR <= 1'b0;
      rx.PARITY_ERROR <= 1'b0;
      rx.OVERRUN <= 1'b0;
    end else begin
      rx.OVERRUN <= load && rx.RX_VALID && !rx.RX_READY;
      if (load) begin
        rx.RX_DATA <= sh;
        rx.FRAME_ERROR <= ferr;
        rx.PARITY_ERROR <= perr;
        rx.RX_VALID <= 1'b1;
      end else if (rx.RX_READY) begin
        rx.RX_VALID <= 1'b0;
      end
    end
  end
endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Parametrised next-generation UART receive controller: detects start bit, samples mid-bit on an oversampling tick, shifts in LSB-first data, checks stop bit(s), and presents bytes on a valid/ready output.
- Sits between the pad-side RXD line plus baud tick generator and the RX FIFO / consumer logic.
- Adds over the previous RX control unit: single-clock operation, oversampled mid-bit sampling, false-start rejection, variable data/stop width, overrun flagging, optional parity.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9.
- OVERSAMPLE, 16, SAMPLE_TICK pulses per bit period; even, >= 4.
- STOP_BITS, 1, stop bits checked; legal 1 or 2.

Ports:
- CLK, input, 1, sole clock.
- RST, input, 1, synchronous active-high reset.
- SAMPLE_TICK, input, 1, one-CLK enable pulse at OVERSAMPLE x baud rate.
- RXD, input, 1, asynchronous serial line; idles high.
- PARITY_ODD, input, 1, 1 = odd parity, 0 = even; quasi-static; ignored when the parity feature is off.
- RX_DATA, output, DATA_BITS, received word; bit 0 is the first bit received.
- RX_VALID, output, 1, RX_DATA holds an unconsumed word.
- RX_READY, input, 1, consumer accepts RX_DATA when RX_VALID & RX_READY.
- RXRDY, output, 1, receiver idle (FSM in IDLE).
- FRAME_ERROR, output, 1, the word in RX_DATA had a low stop bit.
- PARITY_ERROR, output, 1, the word in RX_DATA failed parity; tied 0 without the feature.
- OVERRUN, output, 1, one-CLK pulse when an unconsumed word is overwritten.

Behaviour:
- Interface is fixed: one clock, CLK; reset is synchronous and active-high, RST.
- Reset values: RX_DATA=0, RX_VALID=0, RXRDY=1, FRAME_ERROR=0, PARITY_ERROR=0, OVERRUN=0, FSM=IDLE, counters=0, synchroniser flops=1.
- RXD passes through a 2-flop synchroniser. Falling edge = previous synced value 1 and current synced value 0, evaluated every CLK, not only on ticks.
- FSM states: IDLE, START, DATA, PARITY, STOP. Tick counter is $clog2(OVERSAMPLE) bits; bit counter is $clog2(DATA_BITS+1) bits.
- IDLE:
  - Falling edge -> START; tick counter cleared.
- START:
  - Count ticks. At tick OVERSAMPLE/2 - 1 (mid start bit), sample.
  - Sample 1: false start, go to IDLE, no output change.
  - Sample 0: go to DATA; tick and bit counters cleared.
- DATA:
  - On every OVERSAMPLE-th tick (mid-bit), shift the synced RXD into the shift register MSB; bits end right-aligned, LSB first.
  - After DATA_BITS samples -> PARITY if the feature is on, else STOP.
- PARITY (feature only):
  - One mid-bit sample; compute error vs PARITY_ODD.
  - Go to STOP.
- STOP:
  - STOP_BITS mid-bit samples. Frame error if any sample is 0.
  - After the last sample, load the output stage in the next CLK and return to IDLE immediately (mid stop bit), so back-to-back frames are caught.
- Output stage load (one CLK): RX_DATA <= shift register; FRAME_ERROR/PARITY_ERROR <= frame flags; RX_VALID <= 1.
  - Flags describe RX_DATA and change only on load.
- Handshake: RX_VALID & RX_READY clears RX_VALID the next cycle; RX_DATA and flags hold.
- Load while RX_VALID=1 and RX_READY=0: overwrite, pulse OVERRUN for one cycle, RX_VALID stays 1.
- Load in the same cycle as the handshake: old word consumed, new word loaded, RX_VALID stays 1, no OVERRUN.
- After a frame error, IDLE requires a new 1->0 edge, so a stuck-low line produces no further frames.
- RXRDY = (FSM == IDLE), registered.
- SAMPLE_TICK low: FSM and counters hold.
- RST mid-frame: the frame is discarded and all outputs take their reset values next cycle.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: the PARITY state exists; one parity bit follows the data. PARITY_ERROR = (XOR of data bits ^ parity bit) != PARITY_ODD.
- Undefined: no PARITY state; DATA goes directly to STOP; PARITY_ERROR is constant 0; PARITY_ODD is unused. Port list is identical in both builds.

Decomposition:
- Package uart_rx_pkg: rx_state_e enum (IDLE, START, DATA, PARITY, STOP) and the legal-range constants MIN_DATA_BITS=5, MAX_DATA_BITS=9.
- Sub-module uart_rx_sync: 2-flop synchroniser plus falling-edge detector, with synchronous reset to 1.
- Parameter legality checked by an elaboration-time assertion.

Test Plan:
- Reset, then 8N1 frame 0xA5 at OVERSAMPLE=16 -> RX_DATA=0xA5, RX_VALID=1, FRAME_ERROR=0; RXRDY low during the frame, high after the stop sample.
- 0 pulse of 6 ticks on idle RXD -> false start; no RX_VALID, FSM returns to IDLE, RXRDY=1.
- Frame 0x3C with a stop bit of 0 -> RX_DATA=0x3C, FRAME_ERROR=1. Line held low afterwards -> no second frame.
- Two back-to-back frames 0x11, 0x22 with RX_READY=0 -> RX_DATA=0x22, OVERRUN pulses once. Repeat with RX_READY=1 in the load cycle -> no OVERRUN.
- With UART_RX_PARITY_EN, PARITY_ODD=0: frame 0x07 with parity bit 1 -> PARITY_ERROR=0; parity bit 0 -> PARITY_ERROR=1.
- DATA_BITS=5, STOP_BITS=2: frame 0x1F with second stop bit 0 -> FRAME_ERROR=1. Also assert RST mid-DATA -> all outputs at reset values next cycle.
